alt_vipitc131_common_pack_data: RTL
===================================

ALT_VIPITC131_COMMON_PACK_DATA -- requirements
Module: alt_vipitc131_common_pack_data

Interface
REQ-001 Parameters: DATA_WIDTH_IN, default 24, user-side word width; DATA_WIDTH_OUT, default 128, memory-side word width; DATA_WIDTH_OUT SHALL be >= DATA_WIDTH_IN.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clock  input  1  sole clock; all state on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH_IN  user word.
- write_in  input  1  user offers data_in this cycle.
- stall_in  output  1  block cannot accept data_in this cycle.
- data_out  output  DATA_WIDTH_OUT  packed memory word.
- write_out  output  1  data_out valid.
- stall_out  input  1  memory side cannot take data_out.
- flush  input  1  single-cycle pulse: zero-pad and emit the partial word.
- clear  input  1  discard all buffered data.

Function
REQ-003 Datapath SHALL be an accumulator of DATA_WIDTH_IN+DATA_WIDTH_OUT bits, a fill counter (0..DATA_WIDTH_IN+DATA_WIDTH_OUT), an output register with valid flag out_valid, and a flush_pending flag.
REQ-004 Bit order SHALL be LSB-first: the first accepted input occupies data_out[DATA_WIDTH_IN-1:0]; a later input starts at bit position fill and may span two output words.
REQ-005 Input accept SHALL occur on a rising edge where write_in=1 and stall_in=0.
REQ-006 Output transfer SHALL occur on a rising edge where write_out=1 and stall_out=0.
REQ-007 write_out SHALL equal out_valid; data_out and write_out SHALL stay stable while stall_out=1.
REQ-008 out_free SHALL be true when out_valid=0 or a transfer occurs this cycle.
REQ-009 Move: when out_free and fill >= DATA_WIDTH_OUT, the output register SHALL load acc[DATA_WIDTH_OUT-1:0], set out_valid=1, shift acc right by DATA_WIDTH_OUT, and decrement fill by DATA_WIDTH_OUT.
REQ-010 In the same cycle, an accepted input SHALL be appended at the post-move fill, and fill SHALL increase by DATA_WIDTH_IN.
REQ-011 stall_in SHALL equal flush_pending OR (fill >= DATA_WIDTH_OUT AND NOT out_free); with stall_out=0, input SHALL be accepted every cycle with no bubbles.
REQ-012 Latency: the word completed by an input accepted at edge E SHALL appear with write_out=1 after edge E+1 if out_free in that cycle.
REQ-013 Flush: the flush pulse SHALL set flush_pending.
REQ-014 While flush_pending: full words SHALL be emitted first per REQ-009; then, if 0 < fill < DATA_WIDTH_OUT and out_free, the output register SHALL load the partial acc with bits at and above fill forced to 0, fill SHALL become 0 and flush_pending SHALL clear.
REQ-015 If flush_pending and fill=0, flush_pending SHALL clear without emitting a word.
REQ-016 A flush asserted while flush_pending is already set SHALL have no extra effect.
REQ-017 Clear SHALL have highest priority and take effect at the next edge: fill=0, flush_pending=0, out_valid=0, accumulator contents don't-care; an input offered or a transfer pending in that cycle SHALL be discarded.
REQ-018 clear and flush in the same cycle SHALL act as clear only.
REQ-019 fill SHALL never exceed DATA_WIDTH_IN+DATA_WIDTH_OUT-1; accepted data SHALL never be dropped or duplicated except by clear.

Reset
REQ-020 While reset_n=0: fill=0, flush_pending=0, out_valid=0, write_out=0, data_out=0, stall_in=0, accumulator=0.
REQ-021 Reset deassertion SHALL need no synchronisation inside the block; the first accept is allowed on the first edge after release.
REQ-022 Reset asserted mid-word or mid-flush SHALL discard all state immediately.

Verification
REQ-023 Reset: assert reset_n=0 mid-stream -> write_out=0, stall_in=0, data_out=0 at once; after release, the first word is built only from new inputs.
REQ-024 IN=32/OUT=128, stall_out=0: inputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> one write_out cycle, data_out=0x44444444_33333333_22222222_11111111, one edge after the 4th accept.
REQ-025 Defaults 24/128, stall_out=0: 16 back-to-back inputs -> stall_in never 1; exactly 3 words; word0[127:120]=input5[7:0], word1[15:0]=input5[23:8].
REQ-026 Backpressure: stall_out=1 with data_out loaded, keep writing -> data_out stable; stall_in=1 once fill>=128; release stall_out -> word transferred and input accepted the same cycle; no loss, checked against a scoreboard.
REQ-027 Flush, defaults: 2 inputs 0xABCDEF, 0x123456, then flush -> data_out=0x...0_123456_ABCDEF (bits 127:48 zero); stall_in=1 until emitted; fill=0 afterwards.
REQ-028 Clear: 3 inputs, then clear together with write_in=1 -> no word emitted, that input discarded; the next 6 inputs form word0 from scratch.

Source files
------------

// File: rtl/alt_vipitc131_common_pack_data.sv
// Packs a stream of narrow user words LSB-first into wide memory words,
// with flush (zero-padded partial word) and clear (discard everything).
module alt_vipitc131_common_pack_data #(
  parameter int DATA_WIDTH_IN  = 24,
  parameter int DATA_WIDTH_OUT = 128
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      write_in,
  output logic                      stall_in,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      write_out,
  input  logic                      stall_out,
  input  logic                      flush,
  input  logic                      clear
);

  localparam int ACC_W  = DATA_WIDTH_IN + DATA_WIDTH_OUT;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(DATA_WIDTH_OUT);
  localparam logic [FILL_W-1:0] IN_FILL  = FILL_W'(DATA_WIDTH_IN);

  logic [ACC_W-1:0]          acc, acc_mid, acc_next;
  logic [FILL_W-1:0]         fill, fill_mid, fill_next;
  logic [DATA_WIDTH_OUT-1:0] data_out_q, data_out_next;
  logic                      out_valid, out_valid_next;
  logic                      flush_pending, flush_pending_next;
  logic                      transfer, out_free, full, accept;

  assign transfer  = out_valid & ~stall_out;
  assign out_free  = ~out_valid | transfer;
  assign full      = (fill >= OUT_FILL);
  assign stall_in  = flush_pending | (full & ~out_free);
  assign accept    = write_in & ~stall_in;
  assign write_out = out_valid;
  assign data_out  = data_out_q;

  // A full word always leaves before a flush pads the remainder, and new input
  // lands on top of whatever is left after that move; bits above the fill
  // level are masked so stale accumulator contents never leak into a word.
  always_comb begin
    acc_mid            = acc;
    fill_mid           = fill;
    data_out_next      = data_out_q;
    out_valid_next     = out_valid & ~transfer;
    flush_pending_next = flush_pending | flush;

    if (out_free && full) begin
      data_out_next  = acc[DATA_WIDTH_OUT-1:0];
      out_valid_next = 1'b1;
      acc_mid        = acc >> DATA_WIDTH_OUT;
      fill_mid       = fill - OUT_FILL;
    end else if (flush_pending && fill == '0) begin
      flush_pending_next = 1'b0;
    end else if (flush_pending && out_free) begin
      data_out_next      = acc[DATA_WIDTH_OUT-1:0] & ~({DATA_WIDTH_OUT{1'b1}} << fill);
      out_valid_next     = 1'b1;
      acc_mid            = '0;
      fill_mid           = '0;
      flush_pending_next = 1'b0;
    end

    acc_next  = acc_mid & ~({ACC_W{1'b1}} << fill_mid);
    fill_next = fill_mid;
    if (accept) begin
      acc_next  = acc_next | (ACC_W'(data_in) << fill_mid);
      fill_next = fill_mid + IN_FILL;
    end

    // Clear overrides everything, including a flush or input in the same cycle.
    if (clear) begin
      acc_next           = '0;
      fill_next          = '0;
      out_valid_next     = 1'b0;
      flush_pending_next = 1'b0;
      data_out_next      = data_out_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc           <= '0;
      fill          <= '0;
      data_out_q    <= '0;
      out_valid     <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      acc           <= acc_next;
      fill          <= fill_next;
      data_out_q    <= data_out_next;
      out_valid     <= out_valid_next;
      flush_pending <= flush_pending_next;
    end
  end

endmodule
